// File: rtl/mips_fetch_pkg.sv
// Shared constants for the MIPS fetch stage: instruction width, PC step,
// the NOP encoding used as the reset value of the head instruction, and the
// default reset PC.
package mips_fetch_pkg;

    localparam int          INST_W       = 32;
    localparam int          PC_STEP      = 4;
    localparam logic [31:0] NOP_INST     = 32'h0000_0000;
    localparam logic [31:0] DEF_RESET_PC = 32'h0000_0000;

endpackage : mips_fetch_pkg

// File: rtl/fetch_fifo.sv
// Circular buffer of {instruction, PC} pairs between the instruction ROM and
// decode. The head value is kept in dedicated registers, so the outputs are
// registered and hold the last head when the queue drains.
module fetch_fifo
    import mips_fetch_pkg::*;
#(
    parameter int ADDR_W = 32,
    parameter int DEPTH  = 4
) (
    input  logic                       i_clk,
    input  logic                       i_rst_n,
    input  logic                       i_flush,
    input  logic                       i_push,
    input  logic [INST_W-1:0]          i_push_inst,
    input  logic [ADDR_W-1:0]          i_push_pc,
    input  logic                       i_pop,
    output logic                       o_valid,
    output logic [INST_W-1:0]          o_head_inst,
    output logic [ADDR_W-1:0]          o_head_pc,
    output logic [$clog2(DEPTH):0]     o_count
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    logic [INST_W-1:0] r_mem_inst [DEPTH];
    logic [ADDR_W-1:0] r_mem_pc   [DEPTH];
    logic [PTR_W-1:0]  r_rd_ptr;
    logic [PTR_W-1:0]  r_wr_ptr;
    logic [CNT_W-1:0]  r_count;
    logic              r_valid;
    logic [INST_W-1:0] r_head_inst;
    logic [ADDR_W-1:0] r_head_pc;

    logic              w_do_push;
    logic              w_do_pop;
    logic [PTR_W-1:0]  w_rd_ptr_nx;
    logic [PTR_W-1:0]  w_wr_ptr_nx;
    logic [CNT_W-1:0]  w_count_nx;
    logic [INST_W-1:0] w_head_inst_nx;
    logic [ADDR_W-1:0] w_head_pc_nx;

    // Flush wins over push and pop; a pop on an empty queue is a no-op.
    always_comb begin
        w_do_push = 1'b0;
        w_do_pop  = 1'b0;
        if (i_flush) begin
            w_do_push = 1'b0;
            w_do_pop  = 1'b0;
        end else begin
            w_do_push = i_push;
            w_do_pop  = i_pop && (r_count != '0);
        end
    end

    // Next pointer/count state; pointers wrap naturally since DEPTH is a power of two.
    always_comb begin
        w_rd_ptr_nx = r_rd_ptr;
        w_wr_ptr_nx = r_wr_ptr;
        w_count_nx  = r_count;
        if (i_flush) begin
            w_rd_ptr_nx = '0;
            w_wr_ptr_nx = '0;
            w_count_nx  = '0;
        end else begin
            if (w_do_push) w_wr_ptr_nx = r_wr_ptr + PTR_W'(1'b1);
            else           w_wr_ptr_nx = r_wr_ptr;
            if (w_do_pop)  w_rd_ptr_nx = r_rd_ptr + PTR_W'(1'b1);
            else           w_rd_ptr_nx = r_rd_ptr;
            case ({w_do_push, w_do_pop})
                2'b10:   w_count_nx = r_count + CNT_W'(1'b1);
                2'b01:   w_count_nx = r_count - CNT_W'(1'b1);
                default: w_count_nx = r_count;
            endcase
        end
    end

    // Next head value: forward the word being written if it lands in the head slot.
    always_comb begin
        w_head_inst_nx = r_head_inst;
        w_head_pc_nx   = r_head_pc;
        if (!i_flush && (w_count_nx != '0)) begin
            if (w_do_push && (w_rd_ptr_nx == r_wr_ptr)) begin
                w_head_inst_nx = i_push_inst;
                w_head_pc_nx   = i_push_pc;
            end else begin
                w_head_inst_nx = r_mem_inst[w_rd_ptr_nx];
                w_head_pc_nx   = r_mem_pc[w_rd_ptr_nx];
            end
        end else begin
            w_head_inst_nx = r_head_inst;
            w_head_pc_nx   = r_head_pc;
        end
    end

    // Storage, pointers, count and registered head outputs.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                r_mem_inst[i] <= NOP_INST;
                r_mem_pc[i]   <= '0;
            end
            r_rd_ptr    <= '0;
            r_wr_ptr    <= '0;
            r_count     <= '0;
            r_valid     <= 1'b0;
            r_head_inst <= NOP_INST;
            r_head_pc   <= '0;
        end else begin
            if (w_do_push) begin
                r_mem_inst[r_wr_ptr] <= i_push_inst;
                r_mem_pc[r_wr_ptr]   <= i_push_pc;
            end
            r_rd_ptr    <= w_rd_ptr_nx;
            r_wr_ptr    <= w_wr_ptr_nx;
            r_count     <= w_count_nx;
            r_valid     <= (w_count_nx != '0);
            r_head_inst <= w_head_inst_nx;
            r_head_pc   <= w_head_pc_nx;
        end
    end

    assign o_valid     = r_valid;
    assign o_head_inst = r_head_inst;
    assign o_head_pc   = r_head_pc;
    assign o_count     = r_count;

endmodule : fetch_fifo

// File: rtl/inst_fetch_queue.sv
// Fetch stage: owns the PC, issues sequential reads to a 1-cycle synchronous
// instruction ROM, and queues returned words for decode. A redirect flushes
// both the queue and the read currently in flight.
module inst_fetch_queue
    import mips_fetch_pkg::*;
#(
    parameter int                ADDR_W   = 32,
    parameter int                DEPTH    = 4,
    parameter logic [ADDR_W-1:0] RESET_PC = ADDR_W'(DEF_RESET_PC)
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              redirect_in,
    input  logic [ADDR_W-1:0] redirect_pc_in,
    output logic [ADDR_W-1:0] imem_addr_out,
    output logic              imem_re_out,
    input  logic [INST_W-1:0] imem_data_in,
    output logic              inst_valid_out,
    input  logic              inst_ready_in,
    output logic [INST_W-1:0] inst_out,
    output logic [ADDR_W-1:0] pc_out,
    output logic [ADDR_W-1:0] pc_plus4_out
);

    localparam int CNT_W = $clog2(DEPTH) + 1;

    logic [ADDR_W-1:0] r_fetch_pc;
    logic              r_inflight;
    logic [ADDR_W-1:0] r_inflight_pc;

    logic [CNT_W-1:0]  w_count;
    logic [CNT_W:0]    w_reserved;
    logic              w_issue;
    logic              w_push;

    // Slots already spoken for: queued words plus the read still in flight.
    assign w_reserved = {1'b0, w_count} + {{CNT_W{1'b0}}, r_inflight};

    // Issue only while reset is released, no redirect is taking effect, and a slot is free.
    always_comb begin
        w_issue = 1'b0;
        if (reset && !redirect_in && (w_reserved < (CNT_W + 1)'(DEPTH))) begin
            w_issue = 1'b1;
        end else begin
            w_issue = 1'b0;
        end
    end

    // A returning word is dropped if a redirect flushes it on arrival.
    assign w_push = r_inflight && !redirect_in;

    // Fetch PC and in-flight tracking; redirect overrides sequential advance.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_fetch_pc    <= RESET_PC;
            r_inflight    <= 1'b0;
            r_inflight_pc <= '0;
        end else begin
            if (redirect_in) begin
                r_fetch_pc <= {redirect_pc_in[ADDR_W-1:2], 2'b00};
            end else if (w_issue) begin
                r_fetch_pc <= r_fetch_pc + ADDR_W'(PC_STEP);
            end else begin
                r_fetch_pc <= r_fetch_pc;
            end
            r_inflight <= w_issue;
            if (w_issue) r_inflight_pc <= r_fetch_pc;
            else         r_inflight_pc <= r_inflight_pc;
        end
    end

    fetch_fifo #(
        .ADDR_W (ADDR_W),
        .DEPTH  (DEPTH)
    ) u_fifo (
        .i_clk       (clock),
        .i_rst_n     (reset),
        .i_flush     (redirect_in),
        .i_push      (w_push),
        .i_push_inst (imem_data_in),
        .i_push_pc   (r_inflight_pc),
        .i_pop       (inst_ready_in),
        .o_valid     (inst_valid_out),
        .o_head_inst (inst_out),
        .o_head_pc   (pc_out),
        .o_count     (w_count)
    );

    assign imem_addr_out = r_fetch_pc;
    assign imem_re_out   = w_issue;
    assign pc_plus4_out  = pc_out + ADDR_W'(PC_STEP);

endmodule : inst_fetch_queue
